// File: rtl/collision_score_unit_if.sv
// Signal bundle between the pipe scroller / top-level FSM and the collision and score stage.
// The master drives the game inputs and reads back the registered results.
interface collision_score_unit_if;
    logic        [1:0]  iState;
    logic signed [16:0] iBirdY;
    logic signed [16:0] iPipe1X;
    logic signed [16:0] iPipe2X;
    logic signed [16:0] iPipe3X;
    logic signed [16:0] iPipe1Y;
    logic signed [16:0] iPipe2Y;
    logic signed [16:0] iPipe3Y;
    logic               oHit;
    logic               oDead;
    logic        [11:0] oScore;
    logic        [11:0] oHighScore;
    logic               oScoreTick;

    modport master (
        output iState, iBirdY,
        output iPipe1X, iPipe2X, iPipe3X,
        output iPipe1Y, iPipe2Y, iPipe3Y,
        input  oHit, oDead, oScore, oHighScore, oScoreTick
    );

    modport slave (
        input  iState, iBirdY,
        input  iPipe1X, iPipe2X, iPipe3X,
        input  iPipe1Y, iPipe2Y, iPipe3Y,
        output oHit, oDead, oScore, oHighScore, oScoreTick
    );
endinterface

// File: rtl/collision_score_unit.sv
// Game-rule stage: detects bird collisions with pipes, ground and ceiling, keeps a
// saturating 3-digit BCD score of pipes cleared and the best score since reset.
module collision_score_unit #(
    parameter int BIRD_X          = 160,
    parameter int BIRD_W          = 34,
    parameter int BIRD_H          = 24,
    parameter int PIPE_WIDTH      = 52,
    parameter int PIPE_GAP_HEIGHT = 100,
    parameter int GROUND_Y        = 400
) (
    input logic                  iClock,
    input logic                  iReset,
    collision_score_unit_if.slave bus
);

    localparam logic signed [16:0] BirdXS   = signed'(17'(BIRD_X));
    localparam logic signed [16:0] BirdWS   = signed'(17'(BIRD_W));
    localparam logic signed [16:0] BirdHS   = signed'(17'(BIRD_H));
    localparam logic signed [16:0] PipeWS   = signed'(17'(PIPE_WIDTH));
    localparam logic signed [16:0] GapS     = signed'(17'(PIPE_GAP_HEIGHT));
    localparam logic signed [16:0] GroundS  = signed'(17'(GROUND_Y));

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } stateT;

    stateT              stateQ, stateD;
    logic               hitQ, hitD;
    logic               deadQ, deadD;
    logic               tickQ, tickD;
    logic        [11:0] scoreQ, scoreD;
    logic        [11:0] highQ, highD;
    logic        [2:0]  passedQ, passedD;
    logic               overSeenQ;

    logic signed [16:0] pipeX [3];
    logic signed [16:0] pipeY [3];
    logic        [2:0]  pipeActive;
    logic        [2:0]  pipeHit;
    logic               boundaryHit;
    logic               anyCollision;
    logic        [2:0]  rising;
    logic        [1:0]  eventCount;
    logic               evaluate;
    logic               gameOverIn;
    logic        [11:0] scoreSum;

    assign pipeX[0]   = bus.iPipe1X;
    assign pipeX[1]   = bus.iPipe2X;
    assign pipeX[2]   = bus.iPipe3X;
    assign pipeY[0]   = bus.iPipe1Y;
    assign pipeY[1]   = bus.iPipe2Y;
    assign pipeY[2]   = bus.iPipe3Y;
    assign gameOverIn = bus.iState[1];

    // Adds 0..3 to a BCD score with decimal carry, pinning the result at 999.
    function automatic logic [11:0] bcdAddSat(input logic [11:0] value, input logic [1:0] inc);
        logic [4:0] ones;
        logic [4:0] tens;
        logic [4:0] hund;
        ones = {1'b0, value[3:0]} + {3'b000, inc};
        tens = {1'b0, value[7:4]};
        hund = {1'b0, value[11:8]};
        if (ones > 5'd9) begin
            ones = ones - 5'd10;
            tens = tens + 5'd1;
        end
        if (tens > 5'd9) begin
            tens = tens - 5'd10;
            hund = hund + 5'd1;
        end
        if (hund > 5'd9) begin
            return 12'h999;
        end
        return {hund[3:0], tens[3:0], ones[3:0]};
    endfunction

    // Geometry: all sums stay in signed 17-bit so pipes partly off-screen compare correctly.
    always_comb begin
        pipeActive = '0;
        pipeHit    = '0;
        for (int k = 0; k < 3; k++) begin
            pipeActive[k] = (pipeY[k] != '1);
            pipeHit[k]    = pipeActive[k]
                          && (pipeX[k] < BirdXS + BirdWS)
                          && (pipeX[k] + PipeWS > BirdXS)
                          && ((bus.iBirdY < pipeY[k]) || (bus.iBirdY + BirdHS > pipeY[k] + GapS));
        end
        boundaryHit  = (bus.iBirdY + BirdHS > GroundS) || (bus.iBirdY < 17'sd0);
        anyCollision = boundaryHit || (pipeHit != 3'b000);
    end

    // Passed flags track every state except idle, so a pipe already behind the bird
    // is not counted again when play resumes.
    always_comb begin
        passedD = passedQ;
        if (bus.iState == 2'd0) begin
            passedD = '0;
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (pipeActive[k] && (pipeX[k] + PipeWS < BirdXS)) begin
                    passedD[k] = 1'b1;
                end else if (pipeX[k] >= BirdXS) begin
                    passedD[k] = 1'b0;
                end
            end
        end
        rising     = passedD & ~passedQ;
        eventCount = 2'(rising[0]) + 2'(rising[1]) + 2'(rising[2]);
    end

    always_comb begin
        stateD   = stateQ;
        hitD     = 1'b0;
        evaluate = 1'b0;
        if (bus.iState == 2'd0) begin
            stateD = IDLE;
        end else if ((stateQ == DEAD) || (bus.iState != 2'd1)) begin
            stateD = DEAD;
        end else begin
            evaluate = 1'b1;
            if (anyCollision) begin
                stateD = DEAD;
                hitD   = 1'b1;
            end else begin
                stateD = PLAY;
            end
        end
    end

    // A collision in the same cycle as a pass wins, so the score only moves on a clean cycle.
    always_comb begin
        scoreSum = bcdAddSat(scoreQ, eventCount);
        scoreD   = scoreQ;
        tickD    = 1'b0;
        deadD    = deadQ | hitD;
        if (bus.iState == 2'd0) begin
            scoreD = '0;
            deadD  = 1'b0;
        end else if (evaluate && !anyCollision && (scoreSum != scoreQ)) begin
            scoreD = scoreSum;
            tickD  = 1'b1;
        end
        highD = highQ;
        if (hitQ || (gameOverIn && !overSeenQ)) begin
            highD = (scoreQ > highQ) ? scoreQ : highQ;
        end
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            stateQ    <= IDLE;
            hitQ      <= 1'b0;
            deadQ     <= 1'b0;
            tickQ     <= 1'b0;
            scoreQ    <= '0;
            highQ     <= '0;
            passedQ   <= '0;
            overSeenQ <= 1'b0;
        end else begin
            stateQ    <= stateD;
            hitQ      <= hitD;
            deadQ     <= deadD;
            tickQ     <= tickD;
            scoreQ    <= scoreD;
            highQ     <= highD;
            passedQ   <= passedD;
            overSeenQ <= gameOverIn;
        end
    end

    assign bus.oHit       = hitQ;
    assign bus.oDead      = deadQ;
    assign bus.oScore     = scoreQ;
    assign bus.oHighScore = highQ;
    assign bus.oScoreTick = tickQ;

endmodule

// File: tb/tb_collision_score_unit.sv
// Bench for collision_score_unit: directed game scenarios followed by a random scrolling
// session, every cycle compared against a decimal-arithmetic model of the game rules.
module tb_collision_score_unit;

    localparam int BirdX  = 160;
    localparam int BirdW  = 34;
    localparam int BirdH  = 24;
    localparam int PipeW  = 52;
    localparam int GapH   = 100;
    localparam int Ground = 400;

    logic iClock = 1'b0;
    logic iReset;

    always #5 iClock = ~iClock;

    collision_score_unit_if bus();

    collision_score_unit dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus.slave)
    );

    int checks   = 0;
    int failures = 0;

    bit rstIn;
    int stIn;
    int birdY;
    int pipeX [3];
    int pipeY [3];

    int mScore;
    int mHigh;
    bit mHit;
    bit mTick;
    bit mDead;
    bit mRoundOver;
    bit mPrevOver;
    bit mFlag [3];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic int toBcd(input int v);
        return (v / 100) * 256 + ((v / 10) % 10) * 16 + (v % 10);
    endfunction

    function automatic bit pipeCollides(input int k);
        if (pipeY[k] == -1) return 1'b0;
        if (!(pipeX[k] < BirdX + BirdW && pipeX[k] + PipeW > BirdX)) return 1'b0;
        return (birdY < pipeY[k]) || (birdY + BirdH > pipeY[k] + GapH);
    endfunction

    // Game rules applied to the inputs sampled at one clock edge.
    task automatic stepModel();
        bit coll;
        bit newFlag;
        int events;
        int newScore;
        if (rstIn) begin
            mScore = 0; mHigh = 0; mHit = 0; mTick = 0; mDead = 0;
            mRoundOver = 0; mPrevOver = 0;
            for (int k = 0; k < 3; k++) mFlag[k] = 0;
        end else begin
            if ((mHit || (stIn >= 2 && !mPrevOver)) && mScore > mHigh) mHigh = mScore;
            mHit = 0;
            mTick = 0;
            mPrevOver = (stIn >= 2);
            if (stIn == 0) begin
                mScore = 0; mDead = 0; mRoundOver = 0;
                for (int k = 0; k < 3; k++) mFlag[k] = 0;
            end else begin
                coll = (birdY + BirdH > Ground) || (birdY < 0);
                for (int k = 0; k < 3; k++) coll = coll || pipeCollides(k);
                events = 0;
                for (int k = 0; k < 3; k++) begin
                    newFlag = mFlag[k];
                    if (pipeY[k] != -1 && pipeX[k] + PipeW < BirdX) newFlag = 1;
                    else if (pipeX[k] >= BirdX) newFlag = 0;
                    if (newFlag && !mFlag[k]) events++;
                    mFlag[k] = newFlag;
                end
                if (stIn == 1 && !mRoundOver) begin
                    if (coll) begin
                        mHit = 1; mDead = 1; mRoundOver = 1;
                    end else if (events > 0) begin
                        newScore = (mScore + events > 999) ? 999 : mScore + events;
                        mTick = (newScore != mScore);
                        mScore = newScore;
                    end
                end else begin
                    mRoundOver = 1;
                end
            end
        end
    endtask

    task automatic applyStimulus();
        iReset          = rstIn;
        bus.iState      = 2'(stIn);
        bus.iBirdY      = 17'(birdY);
        bus.iPipe1X     = 17'(pipeX[0]);
        bus.iPipe2X     = 17'(pipeX[1]);
        bus.iPipe3X     = 17'(pipeX[2]);
        bus.iPipe1Y     = 17'(pipeY[0]);
        bus.iPipe2Y     = 17'(pipeY[1]);
        bus.iPipe3Y     = 17'(pipeY[2]);
        @(posedge iClock);
        stepModel();
        #1;
        checkOutput("hit",   32'(bus.oHit),       32'(mHit));
        checkOutput("dead",  32'(bus.oDead),      32'(mDead));
        checkOutput("tick",  32'(bus.oScoreTick), 32'(mTick));
        checkOutput("score", 32'(bus.oScore),     toBcd(mScore));
        checkOutput("high",  32'(bus.oHighScore), toBcd(mHigh));
    endtask

    task automatic setIdlePipes();
        for (int k = 0; k < 3; k++) begin
            pipeX[k] = 400;
            pipeY[k] = -1;
        end
    endtask

    task automatic startRound();
        stIn = 0;
        setIdlePipes();
        birdY = 230;
        applyStimulus();
        stIn = 1;
    endtask

    task automatic passOnce();
        pipeY[0] = 200;
        birdY    = 230;
        pipeX[0] = 200;
        applyStimulus();
        pipeX[0] = 100;
        applyStimulus();
    endtask

    task automatic doReset();
        rstIn = 1;
        stIn  = 0;
        applyStimulus();
        rstIn = 0;
    endtask

    initial begin
        rstIn = 1;
        stIn  = 0;
        birdY = 200;
        setIdlePipes();
        applyStimulus();
        applyStimulus();
        checkOutput("rstScore", 32'(bus.oScore), 32'h000);
        checkOutput("rstHigh",  32'(bus.oHighScore), 32'h000);
        rstIn = 0;

        // Pipe collision and the gap that clears it
        startRound();
        pipeX[0] = 150; pipeY[0] = 100; birdY = 50;
        applyStimulus();
        checkOutput("pipeHit", 32'(bus.oHit), 32'h1);
        applyStimulus();
        checkOutput("hitOneCycle", 32'(bus.oHit), 32'h0);
        checkOutput("deadHeld", 32'(bus.oDead), 32'h1);
        startRound();
        pipeX[0] = 150; pipeY[0] = 100; birdY = 130;
        applyStimulus();
        checkOutput("gapNoHit", 32'(bus.oHit), 32'h0);

        // Single pass scored exactly once
        startRound();
        pipeY[0] = 200; birdY = 230;
        for (int x = 110; x >= 108; x--) begin
            pipeX[0] = x;
            applyStimulus();
        end
        checkOutput("x108NoTick", 32'(bus.oScoreTick), 32'h0);
        pipeX[0] = 107;
        applyStimulus();
        checkOutput("x107Tick", 32'(bus.oScoreTick), 32'h1);
        checkOutput("x107Score", 32'(bus.oScore), 32'h001);
        repeat (10) applyStimulus();
        checkOutput("holdNoTick", 32'(bus.oScoreTick), 32'h0);

        // Decimal carry and saturation
        repeat (98) passOnce();
        checkOutput("score99", 32'(bus.oScore), 32'h099);
        passOnce();
        checkOutput("carry100", 32'(bus.oScore), 32'h100);
        repeat (899) passOnce();
        checkOutput("score999", 32'(bus.oScore), 32'h999);
        passOnce();
        checkOutput("satScore", 32'(bus.oScore), 32'h999);
        checkOutput("satNoTick", 32'(bus.oScoreTick), 32'h0);
        stIn = 2;
        applyStimulus();
        checkOutput("overHigh999", 32'(bus.oHighScore), 32'h999);

        // Invalid pipe and the ground/ceiling boundaries
        startRound();
        pipeX[1] = 150; pipeY[1] = -1; birdY = 0;
        applyStimulus();
        checkOutput("invalidNoHit", 32'(bus.oHit), 32'h0);
        birdY = 377;
        applyStimulus();
        checkOutput("groundHit", 32'(bus.oHit), 32'h1);
        startRound();
        birdY = -1;
        applyStimulus();
        checkOutput("ceilingHit", 32'(bus.oHit), 32'h1);

        // Pass and ground collision in the same cycle
        doReset();
        startRound();
        passOnce();
        passOnce();
        pipeX[0] = 200;
        applyStimulus();
        pipeX[0] = 107; birdY = 377;
        applyStimulus();
        checkOutput("simulHit", 32'(bus.oHit), 32'h1);
        checkOutput("simulNoTick", 32'(bus.oScoreTick), 32'h0);
        checkOutput("simulScore", 32'(bus.oScore), 32'h002);
        applyStimulus();
        checkOutput("simulHigh", 32'(bus.oHighScore), 32'h002);

        // High score over a restart and a reset
        doReset();
        startRound();
        repeat (7) passOnce();
        birdY = 377;
        applyStimulus();
        applyStimulus();
        checkOutput("high7", 32'(bus.oHighScore), 32'h007);
        startRound();
        repeat (12) passOnce();
        stIn = 2;
        applyStimulus();
        checkOutput("high12", 32'(bus.oHighScore), 32'h012);
        stIn = 0;
        applyStimulus();
        checkOutput("idleScore", 32'(bus.oScore), 32'h000);
        checkOutput("idleHigh", 32'(bus.oHighScore), 32'h012);
        checkOutput("idleDead", 32'(bus.oDead), 32'h0);
        doReset();
        checkOutput("resetHigh", 32'(bus.oHighScore), 32'h000);

        // Random scrolling session
        stIn  = 1;
        birdY = 200;
        for (int k = 0; k < 3; k++) begin
            pipeX[k] = 200 + k * 170;
            pipeY[k] = int'($urandom_range(20, 300));
        end
        for (int i = 0; i < 1500; i++) begin
            rstIn = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 39) == 0) stIn = int'($urandom_range(0, 3));
            else if (stIn != 1 && $urandom_range(0, 7) == 0) stIn = 1;
            birdY = birdY + int'($urandom_range(0, 12)) - 6;
            if (birdY < -30) birdY = -30;
            if (birdY > 430) birdY = 430;
            for (int k = 0; k < 3; k++) begin
                pipeX[k] = pipeX[k] - int'($urandom_range(1, 4));
                if (pipeX[k] < -70) begin
                    pipeX[k] = 300 + int'($urandom_range(0, 200));
                    pipeY[k] = ($urandom_range(0, 4) == 0) ? -1 : int'($urandom_range(20, 300));
                end
            end
            applyStimulus();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
